// File: rtl/poly_drv_pkg.sv
// Shared types and defaults for the polynomial-evaluator load sequencer.
package poly_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PRESS,
    RELEASE,
    WAIT_RESULT,
    RESPOND
  } state_t;

  typedef logic [1:0] op_idx_t;

  localparam op_idx_t OP_A = 2'd0;
  localparam op_idx_t OP_B = 2'd1;
  localparam op_idx_t OP_C = 2'd2;
  localparam op_idx_t OP_X = 2'd3;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_GO_CYCLES  = 2;
  localparam int DEF_GAP_CYCLES = 1;
  localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/go_strobe_gen.sv
// One operand load: 1 setup cycle, GO_CYCLES with go high, GAP_CYCLES low; done on last gap cycle.
// A start on the done cycle chains straight into the next setup with no idle bubble.
module go_strobe_gen
  import poly_drv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GO_CYCLES  = DEF_GO_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             go,
  output logic [WIDTH-1:0] load_data,
  output logic             done,
  output state_t           phase_next
);

  localparam int CNT_MAX = (GO_CYCLES > GAP_CYCLES) ? GO_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           phase;
  state_t           phase_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             press_last;
  logic             gap_last;

  assign press_last = (cnt == CNT_W'(GO_CYCLES - 1));
  assign gap_last   = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign done       = (phase == RELEASE) && gap_last;
  assign phase_next = phase_n;

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    case (phase)
      SETUP: begin
        phase_n = PRESS;
        cnt_n   = '0;
      end
      PRESS: begin
        if (press_last) begin
          phase_n = RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (gap_last) phase_n = IDLE;
        else          cnt_n   = cnt + 1'b1;
      end
      default: phase_n = IDLE;
    endcase
    if (start && ((phase == IDLE) || done)) phase_n = SETUP;
  end

  // load_data only changes on entry to SETUP, so it is stable across the whole press/release window
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      phase     <= IDLE;
      cnt       <= '0;
      go        <= 1'b0;
      load_data <= '0;
    end else begin
      phase <= phase_n;
      cnt   <= cnt_n;
      go    <= (phase_n == PRESS);
      if (phase_n == SETUP) load_data <= data;
    end
  end

endmodule

// File: rtl/poly_eval_driver.sv
// Loads A,B,C,X into the evaluator with Go strobes, waits for ResultValid (or TIMEOUT) and returns it.
// One request in flight; req_ready only in IDLE; the response is held until rsp_ready.
module poly_eval_driver
  import poly_drv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GO_CYCLES  = DEF_GO_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  input  logic [WIDTH-1:0] req_x,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             Go,
  output logic [WIDTH-1:0] DataIn,
  input  logic             ResultValid,
  input  logic [WIDTH-1:0] DataResult
);

  localparam int TW = $clog2(TIMEOUT);

  state_t                state;
  state_t                state_n;
  logic [3:0][WIDTH-1:0] ops;
  logic [3:0][WIDTH-1:0] ops_n;
  op_idx_t               idx;
  op_idx_t               idx_nxt;
  op_idx_t               sel;
  logic [TW-1:0]         tcnt;
  logic                  req_fire;
  logic                  strobe_start;
  logic                  strobe_done;
  logic [WIDTH-1:0]      strobe_data;
  state_t                strobe_phase_n;
  logic                  load_last;
  logic                  expired;

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign req_fire     = req_valid && req_ready;
  assign idx_nxt      = idx + 2'd1;
  assign load_last    = strobe_done && (idx == OP_X);
  assign strobe_start = req_fire || (strobe_done && (idx != OP_X));
  assign ops_n        = req_fire ? {req_x, req_c, req_b, req_a} : ops;
  assign sel          = req_fire ? OP_A : idx_nxt;
  assign strobe_data  = ops_n[sel];
  assign expired      = (tcnt == TW'(TIMEOUT - 1));

  go_strobe_gen #(
    .WIDTH     (WIDTH),
    .GO_CYCLES (GO_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_strobe (
    .core_clk  (Clock),
    .arst_n    (Resetn),
    .start     (strobe_start),
    .data      (strobe_data),
    .go        (Go),
    .load_data (DataIn),
    .done      (strobe_done),
    .phase_next(strobe_phase_n)
  );

  // During the load the top state tracks the strobe generator's phase one-for-one
  always_comb begin
    state_n = state;
    case (state)
      IDLE:                  if (req_fire) state_n = SETUP;
      SETUP, PRESS, RELEASE: state_n = load_last ? WAIT_RESULT : strobe_phase_n;
      WAIT_RESULT:           if (ResultValid || expired) state_n = RESPOND;
      RESPOND:               if (rsp_ready) state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      ops         <= '0;
      idx         <= OP_A;
      tcnt        <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ops   <= ops_n;
      if (req_fire)                           idx <= OP_A;
      else if (strobe_done && (idx != OP_X))  idx <= idx_nxt;
      if (load_last)                  tcnt <= '0;
      else if (state == WAIT_RESULT)  tcnt <= tcnt + 1'b1;
      // A result arriving on the expiry cycle takes priority over the timeout
      if ((state == WAIT_RESULT) && (ResultValid || expired)) begin
        rsp_valid   <= 1'b1;
        rsp_data    <= ResultValid ? DataResult : '0;
        rsp_timeout <= !ResultValid;
      end else if ((state == RESPOND) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_eval_driver.sv
// Directed + randomized bench: a behavioural evaluator answers Go/DataIn loads after a chosen latency.
module tb_poly_eval_driver;

  localparam int W   = 8;
  localparam int GO  = 2;
  localparam int GAP = 1;
  localparam int TO  = 16;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0, req_b = '0, req_c = '0, req_x = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_timeout;
  logic         busy;
  logic         Go;
  logic [W-1:0] DataIn;
  logic         ResultValid = 1'b0;
  logic [W-1:0] DataResult = '0;

  always #5 Clock = ~Clock;

  poly_eval_driver #(.WIDTH(W), .GO_CYCLES(GO), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_x(req_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy),
    .Go(Go), .DataIn(DataIn),
    .ResultValid(ResultValid), .DataResult(DataResult)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit noise    = 0;

  function automatic logic [W-1:0] poly(input logic [W-1:0] a, b, c, x);
    logic [W-1:0] t;
    t = a * x + b;
    t = t * x;
    t = t + c;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluator model: loads DataIn on each Go rise, answers ev_lat negedges after the X load (<0: never)
  int           ev_lat = 4;
  int           ev_cnt = 0;
  bit           ev_run = 0;
  int           ld_idx = 0;
  logic [W-1:0] ld_ops [4];
  logic         go_prev = 1'b0;
  logic [W-1:0] din_prev = '0;
  logic [W-1:0] cur_val = '0;
  int           cur_len = 0;
  bit           unstable = 0;
  int           pulse_len [$];
  logic [W-1:0] pulse_val [$];
  int           xc = 0;

  always @(negedge Clock) begin
    if (!Resetn) begin
      ld_idx = 0; ev_run = 0; ResultValid = 1'b0; cur_len = 0;
    end else begin
      xc++;
      if (Go && !go_prev) begin
        if (DataIn !== din_prev) unstable = 1;
        cur_val = DataIn; cur_len = 1;
        ld_ops[ld_idx] = DataIn;
        if (ld_idx == 0) begin ResultValid = 1'b0; ev_run = 0; end
        if (ld_idx == 3) begin ev_run = 1; ev_cnt = 0; xc = 0; ld_idx = 0; end
        else ld_idx++;
      end else if (Go) begin
        cur_len++;
        if (DataIn !== cur_val) unstable = 1;
      end else if (go_prev) begin
        pulse_len.push_back(cur_len);
        pulse_val.push_back(cur_val);
        if (DataIn !== cur_val) unstable = 1;
      end
      if (ev_run) begin
        if (ev_cnt == ev_lat) begin
          ResultValid = 1'b1;
          DataResult  = poly(ld_ops[0], ld_ops[1], ld_ops[2], ld_ops[3]);
          ev_run = 0;
        end
        ev_cnt++;
      end
    end
    go_prev  = Go;
    din_prev = DataIn;
  end

  task automatic send_req(input logic [W-1:0] a, b, c, x);
    req_a = a; req_b = b; req_c = c; req_x = x; req_valid = 1'b1;
    for (int i = 0; i < 64 && !req_ready; i++) begin @(negedge Clock); #1; end
    check("req_ready_before_accept", req_ready, 1);
    @(posedge Clock); #1;
    req_valid = 1'b0;
    check("busy_after_accept", {req_ready, busy}, 2'b01);
  endtask

  task automatic get_rsp(output logic [W-1:0] d, output logic t, output int l);
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock); #1;
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_a = W'($urandom); req_b = W'($urandom); req_c = W'($urandom); req_x = W'($urandom);
      end
      if (rsp_valid) break;
    end
    check("rsp_valid_within_budget", rsp_valid, 1);
    d = rsp_data; t = rsp_timeout; l = xc;
  endtask

  task automatic finish_rsp(input int hold, input logic [W-1:0] d);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_a = W'($urandom); req_x = W'($urandom);
      @(negedge Clock); #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, d);
      check("hold_req_ready_low", req_ready, 0);
      check("hold_go_low", Go, 0);
    end
    rsp_ready = 1'b1;
    @(posedge Clock); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("rsp_valid_after_handshake", rsp_valid, 0);
    check("idle_after_handshake", {req_ready, busy}, 2'b10);
  endtask

  task automatic run_txn(input string name, input logic [W-1:0] a, b, c, x,
                         input int lat, input int hold);
    logic [W-1:0]          d;
    logic                  t;
    int                    l;
    bit                    exp_to;
    int                    exp_l;
    logic [3:0][W-1:0]     exp_ops;
    ev_lat = lat;
    pulse_len.delete(); pulse_val.delete(); unstable = 0;
    rsp_ready = (hold == 0);
    exp_ops = {x, c, b, a};
    exp_to  = (lat < 0) || (lat > GO + GAP + TO - 1);
    exp_l   = exp_to ? GO + GAP + TO : ((lat > GO + GAP) ? lat : GO + GAP) + 1;
    send_req(a, b, c, x);
    get_rsp(d, t, l);
    check({name, ":rsp_data"}, d, exp_to ? 0 : poly(a, b, c, x));
    check({name, ":rsp_timeout"}, t, exp_to);
    check({name, ":latency_from_x_load"}, l, exp_l);
    check({name, ":go_pulse_count"}, pulse_len.size(), 4);
    foreach (pulse_len[i]) begin
      check({name, ":go_pulse_len"}, pulse_len[i], GO);
      if (i < 4) check({name, ":datain_value"}, pulse_val[i], exp_ops[i]);
    end
    check({name, ":datain_stable"}, unstable, 0);
    finish_rsp(hold, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 Resetn = 1'b0;
    #1;
    check("reset_outputs", {Go, DataIn, rsp_valid, rsp_data, rsp_timeout, busy, req_ready},
          {1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    repeat (2) @(negedge Clock);
    #1 Resetn = 1'b1;
    @(negedge Clock); #1;
    check("idle_after_reset", {Go, DataIn, rsp_valid, busy, req_ready},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});

    run_txn("basic_49", 8'd2, 8'd3, 8'd5, 8'd4, 4, 1);
    noise = 1;
    run_txn("wrap_242", 8'd10, 8'd1, 8'd0, 8'd10, 6, 10);
    noise = 0;
    run_txn("b2b_3", 8'd1, 8'd1, 8'd1, 8'd1, 2, 0);
    run_txn("no_answer", W'($urandom), W'($urandom), W'($urandom), W'($urandom), -1, 2);
    run_txn("tie_result_wins", 8'd7, 8'd9, 8'd200, 8'd3, GO + GAP + TO - 1, 1);
    run_txn("one_late", 8'd7, 8'd9, 8'd200, 8'd3, GO + GAP + TO, 0);

    // Reset during the second press cycle of operand C
    ev_lat = 4; rsp_ready = 1'b0;
    send_req(8'h11, 8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 64; i++) begin
      @(negedge Clock); #1;
      if (Go === 1'b1 && ld_idx == 3 && cur_len == 2) break;
    end
    check("reached_c_second_press", (Go === 1'b1 && ld_idx == 3 && cur_len == 2), 1);
    Resetn = 1'b0;
    #1;
    check("async_reset_go_datain", {Go, DataIn}, 9'h000);
    check("async_reset_busy_ready", {busy, req_ready}, 2'b01);
    @(negedge Clock); #1;
    Resetn = 1'b1;
    @(negedge Clock); #1;
    check("after_reset_release", {Go, rsp_valid, busy, req_ready}, 4'b0001);
    run_txn("after_mid_reset", 8'd5, 8'd6, 8'd7, 8'd8, 5, 1);

    for (int k = 0; k < 10; k++) begin
      run_txn("random", W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              $urandom_range(0, 20), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
